program_loader: RTL and testbench

- Boot/load sequencer for the single-cycle core.
- Accepts a program as a valid/ready word stream and writes it into instruction memory through the instr_mem_address / instr_mem_data / instr_mem_we load path.
- Holds the core in reset and disabled during the load, then releases it to run from word address 0.
- Sits between the host/debug link and the core top level; replaces hand-driven testbench loading.

---
 rtl/program_loader_pkg.sv | 16 +
 rtl/program_loader_checksum.sv | 33 +++
 rtl/program_loader.sv | 134 +++++++++++++
 tb/tb_program_loader.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// Shared types and constants for the program loader.
// Optional checksum stage is enabled with PROGRAM_LOADER_CHECKSUM_EN.
package program_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    FLUSH = 3'd2,
    CHECK = 3'd3,
    RUN   = 3'd4,
    ERROR = 3'd5
  } state_t;

  localparam int DEFAULT_CAPACITY = 1024;

endpackage

// File: rtl/program_loader_checksum.sv
// Checksum accumulator for the program loader: running modulo-2**DATA_WIDTH
// sum of data words plus a zero-compare against the trailing check word.
// Instantiated only when PROGRAM_LOADER_CHECKSUM_EN is defined.
module loader_checksum #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  en,
  input  logic                  clr,
  input  logic                  acc,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  sum_ok
);

  logic [DATA_WIDTH-1:0] sum;

  // Accumulate accepted data words; a new load request clears the sum.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sum <= '0;
    end else if (en) begin
      if (clr)      sum <= '0;
      else if (acc) sum <= sum + data;
    end
  end

  // Check word is valid when it cancels the running sum.
  always_comb begin
    sum_ok = ((sum + data) == '0);
  end

endmodule

// File: rtl/program_loader.sv
// Boot/load sequencer: streams a program into instruction memory while the
// core is held in reset, then releases the core to run from address 0.
// Define PROGRAM_LOADER_CHECKSUM_EN to add a trailing checksum beat.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int DATA_WIDTH        = 32,
  parameter int INST_MEM_CAPACITY = DEFAULT_CAPACITY,
  parameter int CNT_WIDTH         = 11
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  en,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  length,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] instr_mem_address,
  output logic [DATA_WIDTH-1:0] instr_mem_data,
  output logic                  instr_mem_we,
  output logic                  core_rstn,
  output logic                  core_en,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  state_t                state, next_state;
  logic [CNT_WIDTH-1:0]  cnt, cnt_next;
  logic [CNT_WIDTH-1:0]  len, len_next, len_clamp;
  logic                  hs;
  logic                  wr_pend;
  logic [DATA_WIDTH-1:0] wr_addr, wr_data;
  logic                  done_q;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic sum_ok;

  loader_checksum #(.DATA_WIDTH(DATA_WIDTH)) u_checksum (
    .clk    (clk),
    .rstn   (rstn),
    .en     (en),
    .clr    (start),
    .acc    (hs && (state == LOAD)),
    .data   (s_data),
    .sum_ok (sum_ok)
  );
`endif

  // Handshake and status outputs decoded from the current state.
  always_comb begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    s_ready = en && ((state == LOAD) || (state == CHECK));
    busy    = (state == LOAD) || (state == CHECK) || (state == FLUSH);
    error   = (state == ERROR);
`else
    s_ready = en && (state == LOAD);
    busy    = (state == LOAD) || (state == FLUSH);
    error   = 1'b0;
`endif
    hs                = s_valid && s_ready;
    core_rstn         = (state == RUN);
    core_en           = (state == RUN);
    done              = done_q;
    instr_mem_we      = wr_pend && en;
    instr_mem_address = wr_pend ? wr_addr : '0;
    instr_mem_data    = wr_data;
    len_clamp         = (length > CNT_WIDTH'(INST_MEM_CAPACITY)) ?
                        CNT_WIDTH'(INST_MEM_CAPACITY) : length;
  end

  // Next-state logic; start restarts the load from any state.
  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    len_next   = len;
    if (en) begin
      if (start) begin
        len_next   = len_clamp;
        cnt_next   = '0;
        next_state = (len_clamp == '0) ? FLUSH : LOAD;
      end else begin
        case (state)
          LOAD: begin
            if (hs) begin
              cnt_next = cnt + 1'b1;
              if (cnt == len - 1'b1) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                next_state = CHECK;
`else
                next_state = FLUSH;
`endif
              end
            end
          end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          CHECK: begin
            if (hs) next_state = sum_ok ? FLUSH : ERROR;
          end
`endif
          FLUSH:   next_state = RUN;
          default: next_state = state;
        endcase
      end
    end
  end

  // State, counters and the one-deep write register; everything freezes when en=0,
  // so a captured beat stays pending until en returns.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      cnt     <= '0;
      len     <= '0;
      wr_pend <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      done_q  <= 1'b0;
    end else if (en) begin
      state   <= next_state;
      cnt     <= cnt_next;
      len     <= len_next;
      // A data beat is written even when start arrives in the same cycle.
      wr_pend <= hs && (state == LOAD);
      if (hs && (state == LOAD)) begin
        wr_addr <= DATA_WIDTH'(cnt);
        wr_data <= s_data;
      end
      done_q  <= (next_state == RUN) && (state != RUN);
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: driver pushes expected writes per
// accepted beat, monitor pops and compares on every memory write.
module tb_program_loader;

  localparam int DW  = 32;
  localparam int CW  = 11;
  localparam int CAP = 1024;

  logic          clk = 1'b0;
  logic          rstn, en, start, s_valid;
  logic [CW-1:0] length;
  logic [DW-1:0] s_data;
  logic          s_ready, instr_mem_we, core_rstn, core_en, busy, done, error;
  logic [DW-1:0] instr_mem_address, instr_mem_data;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;
  logic [2*DW-1:0] exp_q[$];

  program_loader #(.DATA_WIDTH(DW), .INST_MEM_CAPACITY(CAP), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rstn(rstn), .en(en), .start(start), .length(length),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .instr_mem_address(instr_mem_address), .instr_mem_data(instr_mem_data),
    .instr_mem_we(instr_mem_we), .core_rstn(core_rstn), .core_en(core_en),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else pass_cnt++;
  endtask

  // Monitor: every memory write must match the oldest accepted beat.
  always @(negedge clk) begin
    if (rstn === 1'b1 && instr_mem_we === 1'b1) begin
      chk("we_with_en", {63'd0, en}, 64'd1);
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_write: addr %h data %h, none expected",
                 instr_mem_address, instr_mem_data);
      end else begin
        logic [2*DW-1:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", {32'd0, instr_mem_address}, {32'd0, e[2*DW-1:DW]});
        chk("wr_data", {32'd0, instr_mem_data}, {32'd0, e[DW-1:0]});
      end
    end
  end

  task automatic chk_reset_vals();
    chk("rst_s_ready", {63'd0, s_ready}, 64'd0);
    chk("rst_we", {63'd0, instr_mem_we}, 64'd0);
    chk("rst_addr", {32'd0, instr_mem_address}, 64'd0);
    chk("rst_data", {32'd0, instr_mem_data}, 64'd0);
    chk("rst_core", {62'd0, core_rstn, core_en}, 64'd0);
    chk("rst_status", {61'd0, busy, done, error}, 64'd0);
  endtask

  // One load: random program, optional random valid/en gaps, optional
  // checksum offset (nonzero => bad checksum), optional early return after
  // abort_at accepted beats.
  task automatic load(input int unsigned length_in, input bit rv, input bit re,
                      input logic [DW-1:0] adj, input int unsigned abort_at);
    int unsigned n, total, idx, cyc, acc_cyc, en_cyc, dones;
    logic [DW-1:0] words[$];
    logic [DW-1:0] sum;
    bit exp_err;
    n = (length_in > CAP) ? CAP : length_in;
    sum = '0;
    for (int i = 0; i < int'(n); i++) begin
      words.push_back($urandom);
      sum += words[i];
    end
    total = n;
    exp_err = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    if (n > 0) begin
      words.push_back(-sum + adj);
      total = n + 1;
      exp_err = (adj != '0);
    end
`endif
    @(posedge clk); #1;
    start = 1'b1; length = CW'(length_in); en = 1'b1; s_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    idx = 0; cyc = 0; acc_cyc = 0; en_cyc = 0; dones = 0;
    while (idx < total && cyc < 20000) begin
      s_valid = rv ? 1'($urandom_range(0, 1)) : 1'b1;
      en      = re ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_data  = words[idx];
      @(negedge clk);
      cyc++;
      chk("core_held", {62'd0, core_rstn, core_en}, 64'd0);
      if (s_valid && s_ready) begin
        if (idx < n) exp_q.push_back({DW'(idx), words[idx]});
        idx++;
        acc_cyc = cyc;
      end
      if (abort_at != 0 && idx == abort_at) return;
      @(posedge clk); #1;
    end
    if (idx < total) begin
      total_cnt++;
      $display("FAIL load_timeout: accepted %0d of %0d beats", idx, total);
    end
    s_valid = 1'b1; en = 1'b1; s_data = 32'hDEAD_BEEF;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      cyc++;
      chk("no_extra_ready", {63'd0, s_ready}, 64'd0);
      if (core_en && en_cyc == 0) en_cyc = cyc;
      if (done) dones++;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    chk("done_pulses", 64'(dones), exp_err ? 64'd0 : 64'd1);
    chk("core_released", {62'd0, core_rstn, core_en}, exp_err ? 64'd0 : 64'd3);
    chk("error_flag", {63'd0, error}, {63'd0, exp_err});
    chk("busy_end", {63'd0, busy}, 64'd0);
    if (!re && !exp_err) chk("release_latency", 64'(en_cyc - acc_cyc), 64'd2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0; en = 1'b1; start = 1'b0; s_valid = 1'b0;
    length = '0; s_data = '0;
    #12;
    chk_reset_vals();
    @(negedge clk); rstn = 1'b1;

    load(4, 1'b0, 1'b0, '0, 0);
    load(3, 1'b1, 1'b1, '0, 0);
    load(0, 1'b0, 1'b0, '0, 0);
    load(2000, 1'b0, 1'b0, '0, 0);
    load(10, 1'b1, 1'b0, '0, 0);
    load(8, 1'b0, 1'b0, '0, 3);
    load(5, 1'b1, 1'b0, '0, 0);

    // Asynchronous reset in the middle of a load.
    load(4, 1'b0, 1'b0, '0, 3);
    #2 rstn = 1'b0;
    #1 chk_reset_vals();
    exp_q.delete();
    s_valid = 1'b0;
    @(negedge clk); rstn = 1'b1;
    load(6, 1'b1, 1'b1, '0, 0);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    load(3, 1'b0, 1'b0, '0, 0);
    load(3, 1'b0, 1'b0, 32'h1, 0);
    load(3, 1'b1, 1'b0, '0, 0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
